// File: rtl/teatris_pkg.sv
// Shared definitions for the teatris button front-end: FSM state codes and the debounce default.
package teatris_pkg;

  localparam int unsigned DEBOUNCE_CICLOS_PADRAO = 1000000;

  // Codes are shown as-is on the 7-segment debug display.
  typedef enum logic [3:0] {
    Ocioso        = 4'd0,
    Filtra        = 4'd1,
    Aceita        = 4'd2,
    EsperaSoltura = 4'd3,
    FiltraSoltura = 4'd4
  } estado_t;

  function automatic logic eh_one_hot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer bringing the asynchronous buttons into the clock_50MHz domain.
module sincronizador_2ff #(
  parameter int unsigned LARGURA = 4
) (
  input  logic               clock_50MHz,
  input  logic               reset,
  input  logic [LARGURA-1:0] entrada,
  output logic [LARGURA-1:0] saida
);

  logic [LARGURA-1:0] estagio1;

  always_ff @(posedge clock_50MHz) begin
    if (reset) begin
      estagio1 <= '0;
      saida    <= '0;
    end else begin
      estagio1 <= entrada;
      saida    <= estagio1;
    end
  end

endmodule

// File: rtl/captura_botoes.sv
// Debounces the four play buttons, accepting one one-hot press at a time and requiring a
// filtered release before the next press can be taken.
module captura_botoes
  import teatris_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
  input  logic       clock_50MHz,
  input  logic       reset,
  input  logic [3:0] botoes,
  output logic [3:0] jogada,
  output logic       jogada_valida,
  output logic       tem_jogada,
  output logic [3:0] db_estado
);

  localparam int unsigned LARG_CONT = (DEBOUNCE_CICLOS > 2) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [LARG_CONT-1:0] CONT_MAX = LARG_CONT'(DEBOUNCE_CICLOS - 1);

  logic [3:0]           sync;
  logic [3:0]           candidato;
  logic [LARG_CONT-1:0] contador;
  estado_t              estado;

  sincronizador_2ff #(
    .LARGURA(4)
  ) u_sincronizador (
    .clock_50MHz(clock_50MHz),
    .reset      (reset),
    .entrada    (botoes),
    .saida      (sync)
  );

  always_ff @(posedge clock_50MHz) begin
    if (reset) begin
      estado    <= Ocioso;
      candidato <= '0;
      contador  <= '0;
      jogada    <= '0;
    end else begin
      unique case (estado)
        Ocioso: begin
          // Simultaneous presses are ignored until they resolve to a single button.
          if (eh_one_hot(sync)) begin
            candidato <= sync;
            contador  <= '0;
            estado    <= Filtra;
          end
        end
        Filtra: begin
          if (sync != candidato) begin
            contador <= '0;
            estado   <= Ocioso;
          end else if (contador == CONT_MAX) begin
            jogada <= candidato;
            estado <= Aceita;
          end else begin
            contador <= contador + 1'b1;
          end
        end
        Aceita: begin
          estado <= EsperaSoltura;
        end
        EsperaSoltura: begin
          if (sync == 4'd0) begin
            contador <= '0;
            estado   <= FiltraSoltura;
          end
        end
        FiltraSoltura: begin
          if (sync != 4'd0) begin
            estado <= EsperaSoltura;
          end else if (contador == CONT_MAX) begin
            estado <= Ocioso;
          end else begin
            contador <= contador + 1'b1;
          end
        end
        default: estado <= Ocioso;
      endcase
    end
  end

  assign jogada_valida = (estado == Aceita);
  assign tem_jogada    = (estado == Aceita) || (estado == EsperaSoltura) ||
                         (estado == FiltraSoltura);
  assign db_estado     = estado;

endmodule

// File: tb/tb_captura_botoes.sv
// Table-driven, scoreboarded bench for captura_botoes with DEBOUNCE_CICLOS=4.
module tb_captura_botoes;

  logic       clock_50MHz = 1'b0;
  logic       reset;
  logic [3:0] botoes;
  logic [3:0] jogada;
  logic       jogada_valida;
  logic       tem_jogada;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;

  captura_botoes #(
    .DEBOUNCE_CICLOS(4)
  ) dut (
    .clock_50MHz  (clock_50MHz),
    .reset        (reset),
    .botoes       (botoes),
    .jogada       (jogada),
    .jogada_valida(jogada_valida),
    .tem_jogada   (tem_jogada),
    .db_estado    (db_estado)
  );

  always #10 clock_50MHz = ~clock_50MHz;

  typedef struct {
    logic       rst;
    logic [3:0] b;
    logic [3:0] st;
    logic [3:0] jog;
  } vec_t;

  typedef struct {
    int         idx;
    logic [3:0] st;
    logic [3:0] jog;
    logic       jv;
    logic       tem;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string nome, input int atual, input int esperado);
    checks++;
    if (atual != esperado) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nome, atual, esperado);
    end
  endtask

  // n cycles of the same input and expected state/jogada (after each edge).
  task automatic add(input int n, input logic rst, input logic [3:0] b, input logic [3:0] st,
                     input logic [3:0] jog);
    vec_t v;
    v.rst = rst; v.b = b; v.st = st; v.jog = jog;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // Clean release from ESPERA_SOLTURA: two sync cycles, four filter cycles, then idle.
  task automatic soltura(input logic [3:0] jog);
    add(2, 1'b0, 4'b0000, 4'd3, jog);
    add(4, 1'b0, 4'b0000, 4'd4, jog);
    add(1, 1'b0, 4'b0000, 4'd0, jog);
  endtask

  initial begin
    exp_t e;
    int   lat;
    int   pulsos;

    // Clean press 0010 held 20 cycles, then release.
    add(2, 1'b0, 4'b0010, 4'd0, 4'b0000);
    add(4, 1'b0, 4'b0010, 4'd1, 4'b0000);
    add(1, 1'b0, 4'b0010, 4'd2, 4'b0010);
    add(13, 1'b0, 4'b0010, 4'd3, 4'b0010);
    soltura(4'b0010);
    add(1, 1'b0, 4'b0000, 4'd0, 4'b0010);
    // Bounce on press: 0001 x2, 0000 x1, then 0001 stable.
    add(2, 1'b0, 4'b0001, 4'd0, 4'b0010);
    add(1, 1'b0, 4'b0000, 4'd1, 4'b0010);
    add(1, 1'b0, 4'b0001, 4'd1, 4'b0010);
    add(1, 1'b0, 4'b0001, 4'd0, 4'b0010);
    add(4, 1'b0, 4'b0001, 4'd1, 4'b0010);
    add(1, 1'b0, 4'b0001, 4'd2, 4'b0001);
    add(3, 1'b0, 4'b0001, 4'd3, 4'b0001);
    soltura(4'b0001);
    // Two buttons together are never accepted.
    add(20, 1'b0, 4'b0101, 4'd0, 4'b0001);
    add(2, 1'b0, 4'b0000, 4'd0, 4'b0001);
    // Candidate change mid-filter.
    add(2, 1'b0, 4'b0001, 4'd0, 4'b0001);
    add(1, 1'b0, 4'b0001, 4'd1, 4'b0001);
    add(2, 1'b0, 4'b0100, 4'd1, 4'b0001);
    add(1, 1'b0, 4'b0100, 4'd0, 4'b0001);
    add(4, 1'b0, 4'b0100, 4'd1, 4'b0001);
    add(1, 1'b0, 4'b0100, 4'd2, 4'b0100);
    add(2, 1'b0, 4'b0100, 4'd3, 4'b0100);
    soltura(4'b0100);
    // Release bounce: 0000 x2, 0001 x1, 0000 held.
    add(2, 1'b0, 4'b1000, 4'd0, 4'b0100);
    add(4, 1'b0, 4'b1000, 4'd1, 4'b0100);
    add(1, 1'b0, 4'b1000, 4'd2, 4'b1000);
    add(2, 1'b0, 4'b1000, 4'd3, 4'b1000);
    add(2, 1'b0, 4'b0000, 4'd3, 4'b1000);
    add(1, 1'b0, 4'b0001, 4'd4, 4'b1000);
    add(1, 1'b0, 4'b0000, 4'd4, 4'b1000);
    add(1, 1'b0, 4'b0000, 4'd3, 4'b1000);
    add(4, 1'b0, 4'b0000, 4'd4, 4'b1000);
    add(2, 1'b0, 4'b0000, 4'd0, 4'b1000);
    // Reset mid-FILTRA (counter=2), then full latency restarts; then reset mid-ACEITA.
    add(2, 1'b0, 4'b0010, 4'd0, 4'b1000);
    add(3, 1'b0, 4'b0010, 4'd1, 4'b1000);
    add(1, 1'b1, 4'b0010, 4'd0, 4'b0000);
    add(2, 1'b0, 4'b0010, 4'd0, 4'b0000);
    add(4, 1'b0, 4'b0010, 4'd1, 4'b0000);
    add(1, 1'b0, 4'b0010, 4'd2, 4'b0010);
    add(1, 1'b1, 4'b0010, 4'd0, 4'b0000);
    add(4, 1'b0, 4'b0000, 4'd0, 4'b0000);

    reset  = 1'b1;
    botoes = 4'b0000;
    repeat (2) @(posedge clock_50MHz);
    #1;
    check("reset jogada", int'(jogada), 0);
    check("reset jogada_valida", int'(jogada_valida), 0);
    check("reset tem_jogada", int'(tem_jogada), 0);
    check("reset db_estado", int'(db_estado), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock_50MHz);
      reset  = vecs[i].rst;
      botoes = vecs[i].b;
      e.idx  = i;
      e.st   = vecs[i].st;
      e.jog  = vecs[i].jog;
      e.jv   = (vecs[i].st == 4'd2);
      e.tem  = (vecs[i].st >= 4'd2) && (vecs[i].st <= 4'd4);
      sb.push_back(e);
      @(posedge clock_50MHz);
      #1;
      e = sb.pop_front();
      check($sformatf("vec%0d db_estado", e.idx), int'(db_estado), int'(e.st));
      check($sformatf("vec%0d jogada", e.idx), int'(jogada), int'(e.jog));
      check($sformatf("vec%0d jogada_valida", e.idx), int'(jogada_valida), int'(e.jv));
      check($sformatf("vec%0d tem_jogada", e.idx), int'(tem_jogada), int'(e.tem));
    end
    check("scoreboard drained", sb.size(), 0);

    // Latency measured as edges from first sampling of the press to the pulse.
    @(negedge clock_50MHz);
    botoes = 4'b0100;
    lat = -1;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(posedge clock_50MHz);
      #1;
      if (jogada_valida) lat = k;
    end
    check("press latency", lat, 6);
    check("press jogada", int'(jogada), 4'b0100);
    pulsos = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock_50MHz);
      #1;
      if (jogada_valida) pulsos++;
    end
    check("extra pulses while held", pulses_or(pulsos), 0);

    @(negedge clock_50MHz);
    botoes = 4'b0000;
    lat = -1;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(posedge clock_50MHz);
      #1;
      if (!tem_jogada) lat = k;
    end
    check("release latency", lat, 6);
    check("jogada held after release", int'(jogada), 4'b0100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic int pulses_or(input int p);
    return p;
  endfunction

endmodule

// File: doc/captura_botoes.md
CAPTURA_BOTOES -- requirements
Module: captura_botoes

Interface
REQ-001 SHALL have parameter DEBOUNCE_CICLOS, default 1000000 (20 ms at 50 MHz), legal range >= 2: number of consecutive stable cycles required to accept a press or a release.
REQ-002 SHALL have port clock_50MHz, input, 1 bit: system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the clock_50MHz rising edge.
REQ-004 SHALL have port botoes, input, 4 bits: raw play buttons, asynchronous to the clock, active-high, bouncing.
REQ-005 SHALL have port jogada, output, 4 bits: one-hot code of the last accepted press, registered.
REQ-006 SHALL have port jogada_valida, output, 1 bit: one-cycle pulse, high for exactly one cycle per accepted press.
REQ-007 SHALL have port tem_jogada, output, 1 bit: level, high from press acceptance until the release is filtered.
REQ-008 SHALL have port db_estado, output, 4 bits: current FSM state code, for the 7-segment debug display.

Function
REQ-009 SHALL pass each botoes bit through a 2-flop synchronizer; "sync" below means the 4-bit synchronizer output.
REQ-010 SHALL implement FSM states with db_estado codes: OCIOSO=0, FILTRA=1, ACEITA=2, ESPERA_SOLTURA=3, FILTRA_SOLTURA=4.
REQ-011 In OCIOSO, if sync is exactly one-hot, SHALL latch sync into candidato, clear the counter and go to FILTRA.
REQ-012 In OCIOSO, if sync is 0000 or has more than one bit set, SHALL remain in OCIOSO.
REQ-013 In FILTRA, if sync != candidato, SHALL clear the counter and return to OCIOSO.
REQ-014 In FILTRA, while sync == candidato, SHALL increment the counter each cycle.
REQ-015 In FILTRA, when the counter equals DEBOUNCE_CICLOS-1 and sync == candidato, SHALL go to ACEITA on the next edge.
REQ-016 On the edge entering ACEITA, SHALL load jogada <= candidato.
REQ-017 ACEITA SHALL last exactly one cycle, then go to ESPERA_SOLTURA unconditionally.
REQ-018 jogada_valida SHALL be high only while the state is ACEITA.
REQ-019 In ESPERA_SOLTURA, when sync == 0000, SHALL clear the counter and go to FILTRA_SOLTURA; otherwise it SHALL stay, regardless of any other buttons pressed.
REQ-020 In FILTRA_SOLTURA, if sync != 0000, SHALL return to ESPERA_SOLTURA with no new pulse.
REQ-021 In FILTRA_SOLTURA, while sync == 0000, SHALL count; at counter == DEBOUNCE_CICLOS-1 it SHALL go to OCIOSO on the next edge.
REQ-022 tem_jogada SHALL be high in ACEITA, ESPERA_SOLTURA and FILTRA_SOLTURA, and low otherwise.
REQ-023 Latency: for a clean press first sampled at edge 0 and held, SHALL enter ACEITA at edge DEBOUNCE_CICLOS+2; jogada and jogada_valida change at that edge.
REQ-024 jogada SHALL hold its value until the next accepted press; a new press SHALL NOT be accepted before the release is filtered.
REQ-025 Counter width SHALL be $clog2(DEBOUNCE_CICLOS), minimum 1 bit; the counter SHALL never wrap, because it is cleared or exited at DEBOUNCE_CICLOS-1.

Reset
REQ-026 On reset, SHALL set: state OCIOSO; synchronizer flops, candidato, counter and jogada to 0; outputs jogada=0000, jogada_valida=0, tem_jogada=0, db_estado=0.
REQ-027 Reset SHALL take priority over all transitions, including mid-FILTRA and mid-ACEITA; an ACEITA interrupted by reset SHALL produce no pulse after reset.

Structure
REQ-028 State encodings and the DEBOUNCE_CICLOS default SHALL reside in shared package teatris_pkg.
REQ-029 The synchronizer SHALL be sub-module sincronizador_2ff (4-bit wide, reset to 0); all other logic SHALL be in captura_botoes.

Verification (DEBOUNCE_CICLOS=4)
REQ-030 Clean press: botoes=0010 first sampled at edge 0, held 20 cycles -> jogada=0010 and a single jogada_valida pulse at edge 6; tem_jogada high from edge 6 until 6 cycles after release.
REQ-031 Bounce: botoes 0001 for 2 cycles, 0000 for 1 cycle, then 0001 stable -> exactly one pulse, counted from the last rising of the input; db_estado sequence 1,0,1,...,2,3.
REQ-032 Two buttons: botoes=0101 held 20 cycles -> no pulse; db_estado=0 and jogada unchanged throughout.
REQ-033 Candidate change: 0001 for 3 cycles, then 0100 held -> return to OCIOSO, then jogada=0100 with one pulse only.
REQ-034 Release bounce: after acceptance, 0000 for 2 cycles, 0001 for 1 cycle, 0000 held -> FILTRA_SOLTURA->ESPERA_SOLTURA->FILTRA_SOLTURA->OCIOSO, with no second pulse.
REQ-035 Reset mid-FILTRA (counter=2) -> next cycle all outputs zero, db_estado=0; a held button then restarts the full DEBOUNCE+2 latency.
